instr_encoder_loader: RTL and testbench

Encodes CR16a-style instruction fields into 16-bit instruction words and writes them into instruction memory at consecutive addresses. It is the write-side counterpart of the controller's fetch/decode path, so every word it emits decodes back to the same op, rdest, rsrc and imm8 fields. It sits between a program source (test sequencer or host) and the instruction memory write port. A small FIFO absorbs memory backpressure.

---
 rtl/instr_encoder_loader_pkg.sv | 54 +++++
 rtl/instr_encoder_loader_fifo.sv | 60 ++++++
 rtl/instr_encoder_loader.sv | 139 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared CPU definitions: opcodes, instruction format prefix, loader states
// and the field-to-word encoder used by the instruction loader.
package instr_encoder_loader_pkg;

  // CR16a-style opcodes
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LSH  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_ASHU = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;

  // Top nibble that marks a register-register instruction word
  localparam logic [3:0] RR_PREFIX = 4'b0000;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One instruction's worth of fields as presented by the program source
  typedef struct packed {
    logic       rtype;
    logic [3:0] op;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [7:0] imm8;
  } fields_t;

  // RR: {prefix, rdest, op, rsrc}; immediate: {op, rdest, imm8}
  function automatic logic [15:0] encode(input fields_t f);
    if (f.rtype) begin
      return {RR_PREFIX, f.rdest, f.op, f.rsrc};
    end
    return {f.op, f.rdest, f.imm8};
  endfunction

  // An immediate with opcode 0000 would decode as RR, so it cannot be encoded
  function automatic logic is_illegal(input fields_t f);
    return !f.rtype && (f.op == RR_PREFIX);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Synchronous FIFO with registered pointers; reports full, empty and
// occupancy. Push on full and pop on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer next-state
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 16-bit words and writes them to
// instruction memory at consecutive addresses, buffering through a FIFO.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic              enc_rtype,
  input  logic [3:0]        enc_op,
  input  logic [3:0]        enc_rdest,
  input  logic [3:0]        enc_rsrc,
  input  logic [7:0]        enc_imm8,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrapped,
  output logic [ADDR_W:0]   count
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              wrapped_q, wrapped_d;

  fields_t           fields;
  logic              illegal;
  logic              accept, push, pop;
  logic [15:0]       fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic              last_pop;

  assign fields = '{rtype: enc_rtype, op: enc_op, rdest: enc_rdest,
                    rsrc: enc_rsrc, imm8: enc_imm8};
  assign illegal = is_illegal(fields);

  assign enc_ready = (state_q == ST_LOAD) && !fifo_full;
  assign accept    = enc_valid && enc_ready;
  assign push      = accept && !illegal;

  assign mem_we    = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = ptr_q;
  assign mem_wdata = fifo_empty ? 16'h0000 : fifo_head;

  // The write completing now empties the FIFO, so DONE can follow directly
  assign last_pop = pop && (fifo_level == LW'(1));

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign wrapped = wrapped_q;
  assign count   = count_q;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (encode(fields)),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Session state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Session sequencing: start opens, finish closes input, drain, one-cycle done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)                    state_d = ST_LOAD;
      ST_LOAD:  if (finish)                   state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || last_pop)   state_d = ST_DONE;
      ST_DONE:                                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Write pointer, word count and sticky session flags
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    wrapped_d = wrapped_q;
    if ((state_q == ST_IDLE) && start) begin
      ptr_d     = base_addr;
      count_d   = '0;
      err_d     = 1'b0;
      wrapped_d = 1'b0;
    end else begin
      if (accept && illegal) err_d = 1'b1;
      if (pop) begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (&ptr_q) wrapped_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wrapped_q <= wrapped_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized sessions against a queue-based model of the
// memory write stream (expected words, addresses, count and flags).
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              enc_valid = 1'b0;
  logic              enc_ready;
  logic              enc_rtype = 1'b0;
  logic [3:0]        enc_op = '0;
  logic [3:0]        enc_rdest = '0;
  logic [3:0]        enc_rsrc = '0;
  logic [7:0]        enc_imm8 = '0;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy, done, err, wrapped;
  logic [ADDR_W:0]   count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .finish    (finish),
    .base_addr (base_addr),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .enc_rtype (enc_rtype),
    .enc_op    (enc_op),
    .enc_rdest (enc_rdest),
    .enc_rsrc  (enc_rsrc),
    .enc_imm8  (enc_imm8),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wrapped   (wrapped),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model of the write stream
  int exp_q[$];
  int exp_addr    = 0;
  int exp_count   = 0;
  bit exp_err     = 1'b0;
  bit exp_wrapped = 1'b0;

  function automatic int ref_word(bit rt, int op, int rd, int rs, int imm);
    if (rt) return rd * 256 + op * 16 + rs;
    return op * 4096 + rd * 256 + imm;
  endfunction

  // Memory ready driver: forced level or random per cycle
  bit rand_ready  = 1'b0;
  bit force_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    mem_ready = rand_ready ? 1'($urandom) : force_ready;
  end

  // Write monitor: every completed write must match the model's next word
  bit              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [15:0]     prev_data;
  int              mon_w;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_we", 32'(mem_we), 32'd1);
      check("hold_addr", 32'(mem_addr), 32'(prev_addr));
      check("hold_data", 32'(mem_wdata), 32'(prev_data));
    end
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_addr));
        check("wr_data", 32'(mem_wdata), 32'(mon_w));
        exp_addr = (exp_addr + 1) % (1 << ADDR_W);
        if (exp_addr == 0) exp_wrapped = 1'b1;
        exp_count++;
      end
    end
    prev_stall = mem_we && !mem_ready && !reset;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
  end

  task automatic do_start(input int base);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    exp_q.delete();
    exp_addr    = base;
    exp_count   = 0;
    exp_err     = 1'b0;
    exp_wrapped = 1'b0;
  endtask

  task automatic send(input bit rt, input int op, input int rd, input int rs, input int imm);
    bit ok = 1'b0;
    enc_valid = 1'b1;
    enc_rtype = rt;
    enc_op    = 4'(op);
    enc_rdest = 4'(rd);
    enc_rsrc  = 4'(rs);
    enc_imm8  = 8'(imm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (enc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("enc_ready_timeout", 32'(enc_ready), 32'd1);
    @(posedge clk); #1;
    enc_valid = 1'b0;
    if (ok) begin
      if (!rt && op == 0) exp_err = 1'b1;
      else exp_q.push_back(ref_word(rt, op, rd, rs, imm));
    end
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check(tag, 32'(done), 32'd1);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_wrapped"}, 32'(wrapped), 32'(exp_wrapped));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_enc_ready", 32'(enc_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // RR ADD r3,r5 at base 0x10
    force_ready = 1'b1;
    do_start(32'h10);
    send(1'b1, 5, 3, 5, 0);
    do_finish();
    wait_done("rr_add_done");

    // Immediate word, held by backpressure, checked for latency and decode
    force_ready = 1'b0;
    do_start(0);
    send(1'b0, 5, 2, 0, 8'h7F);
    @(negedge clk);
    check("imm_latency_we", 32'(mem_we), 32'd1);
    check("imm_word", 32'(mem_wdata), 32'h527F);
    check("imm_dec_op", 32'(mem_wdata[15:12]), 32'h5);
    check("imm_dec_rdest", 32'(mem_wdata[11:8]), 32'h2);
    check("imm_dec_imm8", 32'(mem_wdata[7:0]), 32'h7F);
    @(posedge clk); #1;
    force_ready = 1'b1;
    do_finish();
    wait_done("imm_done");

    // FIFO full: four accepted, fifth waits until memory drains
    force_ready = 1'b0;
    do_start(32'h20);
    for (int i = 0; i < 4; i++) send(1'b1, 1 + i, i, 15 - i, 0);
    @(negedge clk);
    check("full_enc_ready", 32'(enc_ready), 32'd0);
    check("full_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    force_ready = 1'b1;
    send(1'b0, 13, 7, 0, 8'hA5);
    do_finish();
    wait_done("full_done");

    // Address wrap
    do_start(32'hFE);
    for (int i = 0; i < 3; i++) send(1'b0, 9, i, 0, 16 * i + 1);
    do_finish();
    wait_done("wrap_done");

    // Illegal field set between two legal ones
    do_start(32'h40);
    send(1'b1, 2, 1, 2, 0);
    send(1'b0, 0, 4, 0, 8'h33);
    send(1'b0, 6, 5, 0, 8'h44);
    do_finish();
    wait_done("illegal_done");

    // New start clears flags; empty session gives done two cycles after finish
    do_start(32'h50);
    @(negedge clk);
    check("restart_err", 32'(err), 32'd0);
    check("restart_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    do_finish();
    @(negedge clk);
    check("empty_drain_done", 32'(done), 32'd0);
    check("empty_drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of DRAIN with three words queued
    force_ready = 1'b0;
    do_start(32'h60);
    for (int i = 0; i < 3; i++) send(1'b1, 11, i, i + 1, 0);
    do_finish();
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_drain_we", 32'(mem_we), 32'd0);
    check("rst_drain_busy", 32'(busy), 32'd0);
    check("rst_drain_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_drain_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    force_ready = 1'b1;
    do_start(32'h70);
    @(negedge clk);
    check("post_rst_fifo_empty", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    send(1'b0, 12, 3, 0, 8'h5A);
    do_finish();
    wait_done("post_rst_done");

    // Randomized sessions with random memory backpressure
    rand_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_start(int'($urandom_range(0, 255)));
      for (int k = 0, n = int'($urandom_range(3, 12)); k < n; k++) begin
        send(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      end
      do_finish();
      wait_done("rand_done");
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
